// File: rtl/led_pkg.sv
// Shared constants and helpers for the board LED running-light demo.
`timescale 1ns / 1ps
package led_pkg;

    localparam int          LED_W           = 4;
    localparam logic [3:0]  LED_INIT        = 4'b0001;
    localparam int unsigned DEF_CLK_FREQ_HZ = 32'd200_000_000;

    function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/IBUFDS.sv
// Behavioural stand-in for the vendor differential input buffer; the vendor
// library cell replaces it in implementation.
`timescale 1ns / 1ps
module IBUFDS (
    input  logic I,
    input  logic IB,
    output logic O
);

    // With complementary legs this reproduces the positive leg exactly.
    assign O = I & ~IB;

endmodule

// File: rtl/led_tick_gen.sv
// Divides clk down to a one-cycle tick every CNT_MAX+1 cycles.
`timescale 1ns / 1ps
module led_tick_gen #(
    parameter logic [31:0] CNT_MAX = 32'd199_999_999
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [31:0] cnt_r;
    logic        tick_r;

    // Counter wraps at CNT_MAX; tick is decoded one count early so the
    // registered tick is high exactly in the cycle where cnt_r == CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 32'd0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= 32'd0;
            end else begin
                cnt_r <= cnt_r + 32'd1;
            end
            tick_r <= (cnt_r == (CNT_MAX - 32'd1));
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/led_blinker.sv
// Board LED indicator: buffers the differential clock and rotates a one-hot
// pattern across the LEDs once per divided tick.
`timescale 1ns / 1ps
module led_blinker
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter logic [31:0] CNT_MAX     = CLK_FREQ_HZ - 32'd1,
    parameter int          LED_W       = led_pkg::LED_W
) (
    input  logic             sys_clk_p,
    input  logic             sys_clk_n,
    input  logic             rst,
    output logic [LED_W-1:0] led
);

    logic             clk_s;
    logic             tick_s;
    logic [LED_W-1:0] led_r;

    IBUFDS u_clk_buf (
        .I  (sys_clk_p),
        .IB (sys_clk_n),
        .O  (clk_s)
    );

    led_tick_gen #(
        .CNT_MAX (CNT_MAX)
    ) u_tick_gen (
        .clk  (clk_s),
        .rst  (rst),
        .tick (tick_s)
    );

    // Running light advances one position per tick and holds otherwise.
    always_ff @(posedge clk_s or posedge rst) begin
        if (rst) begin
            led_r <= LED_INIT;
        end else if (tick_s) begin
            led_r <= rotl(led_r);
        end else begin
            led_r <= led_r;
        end
    end

    assign led = led_r;

endmodule

// File: tb/tb_led_blinker.sv
// Directed scoreboard bench for led_blinker at CNT_MAX=9, CNT_MAX=1 and defaults.
`timescale 1ns / 1ps
module tb_led_blinker;

    logic       sys_clk_p = 1'b0;
    logic       sys_clk_n;
    logic       rst9      = 1'b1;
    logic       rst1      = 1'b1;
    logic       rstd      = 1'b1;
    logic [3:0] led9;
    logic [3:0] led1;
    logic [3:0] ledd;

    int         total     = 0;
    int         bad       = 0;
    int         cycles_d  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;

    always #2.5 sys_clk_p = ~sys_clk_p;
    assign sys_clk_n = ~sys_clk_p;

    led_blinker #(.CNT_MAX(32'd9)) dut9 (
        .sys_clk_p (sys_clk_p),
        .sys_clk_n (sys_clk_n),
        .rst       (rst9),
        .led       (led9)
    );

    led_blinker #(.CNT_MAX(32'd1)) dut1 (
        .sys_clk_p (sys_clk_p),
        .sys_clk_n (sys_clk_n),
        .rst       (rst1),
        .led       (led1)
    );

    led_blinker dutd (
        .sys_clk_p (sys_clk_p),
        .sys_clk_n (sys_clk_n),
        .rst       (rstd),
        .led       (ledd)
    );

    function automatic logic [3:0] exp_led(input int k, input int per);
        logic [3:0] base;
        base = 4'b0001;
        return base << ((k / per) % 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk_p);
        #1;
        if (!rstd) cycles_d++;
    endtask

    initial begin
        // Reset held for 1000 ns with the clock running.
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (i % 20 == 0) begin
                check("rst_led", {28'd0, led9}, 32'h1);
                check("rst_cnt", dut9.u_tick_gen.cnt_r, 32'd0);
            end
        end

        @(negedge sys_clk_p);
        rst9 = 1'b0;
        rstd = 1'b0;

        // First tick, full rotation, wrap and continue into the third period of the next lap.
        for (int k = 1; k <= 65; k++) begin
            exp_q.push_back(exp_led(k, 10));
            cyc();
            exp_v = exp_q.pop_front();
            check($sformatf("run9_k%0d", k), {28'd0, led9}, {28'd0, exp_v});
            check("onehot9", $countones(led9), 32'd1);
        end

        // Asynchronous reset between edges while led is 0100.
        rst9 = 1'b1;
        #1;
        check("async_led", {28'd0, led9}, 32'h1);
        check("async_cnt", dut9.u_tick_gen.cnt_r, 32'd0);
        cyc();
        cyc();
        check("hold_led", {28'd0, led9}, 32'h1);
        check("hold_cnt", dut9.u_tick_gen.cnt_r, 32'd0);
        @(negedge sys_clk_p);
        rst9 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(exp_led(k, 10));
            cyc();
            exp_v = exp_q.pop_front();
            check($sformatf("rerun9_k%0d", k), {28'd0, led9}, {28'd0, exp_v});
        end

        // Minimum terminal count: rotate every two cycles.
        check("min_rst_led", {28'd0, led1}, 32'h1);
        @(negedge sys_clk_p);
        rst1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(exp_led(k, 2));
            cyc();
            exp_v = exp_q.pop_front();
            check($sformatf("min_k%0d", k), {28'd0, led1}, {28'd0, exp_v});
            check("onehot1", $countones(led1), 32'd1);
        end

        // Default divider: still far from its first tick, counter tracks elapsed cycles.
        check("def_led", {28'd0, ledd}, 32'h1);
        check("def_cnt", dutd.u_tick_gen.cnt_r, cycles_d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
